// File: rtl/fxp8s_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fxp8s_pkg: shared FSM encoding and data-width constants for the arbiter.  |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
package fxp8s_pkg;

  localparam int FXP8S_WIDTH   = 8;
  localparam int DATA_W        = FXP8S_WIDTH;
  localparam int BEATS_PER_JOB = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fxp8s_array_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fxp8s_array_arbiter_if: requester and PE-array stream bundle.             |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
interface fxp8s_array_arbiter_if;
  import fxp8s_pkg::*;

  logic              req0_en_in_data, req0_rdy_in_data;
  logic              req0_in_mat, req0_in_new_row, req0_in_mat_done;
  logic [DATA_W-1:0] req0_in_data;
  logic              req0_en_out_data, req0_rdy_out_data;
  logic [DATA_W-1:0] req0_out_data;

  logic              req1_en_in_data, req1_rdy_in_data;
  logic              req1_in_mat, req1_in_new_row, req1_in_mat_done;
  logic [DATA_W-1:0] req1_in_data;
  logic              req1_en_out_data, req1_rdy_out_data;
  logic [DATA_W-1:0] req1_out_data;

  logic              arr_rstn;
  logic              arr_en_in_data, arr_in_mat, arr_in_new_row, arr_in_mat_done;
  logic [DATA_W-1:0] arr_in_data;
  logic              arr_rdy_in_data, arr_en_out_data, arr_rdy_out_data;
  logic [DATA_W-1:0] arr_out_data;

  // Arbiter side
  modport slave (
    input  req0_en_in_data, req0_in_mat, req0_in_new_row, req0_in_mat_done, req0_in_data,
    input  req0_rdy_out_data,
    output req0_rdy_in_data, req0_en_out_data, req0_out_data,
    input  req1_en_in_data, req1_in_mat, req1_in_new_row, req1_in_mat_done, req1_in_data,
    input  req1_rdy_out_data,
    output req1_rdy_in_data, req1_en_out_data, req1_out_data,
    output arr_rstn, arr_en_in_data, arr_in_mat, arr_in_new_row, arr_in_mat_done, arr_in_data,
    output arr_rdy_out_data,
    input  arr_rdy_in_data, arr_en_out_data, arr_out_data
  );

  // Requesters plus PE array side
  modport master (
    output req0_en_in_data, req0_in_mat, req0_in_new_row, req0_in_mat_done, req0_in_data,
    output req0_rdy_out_data,
    input  req0_rdy_in_data, req0_en_out_data, req0_out_data,
    output req1_en_in_data, req1_in_mat, req1_in_new_row, req1_in_mat_done, req1_in_data,
    output req1_rdy_out_data,
    input  req1_rdy_in_data, req1_en_out_data, req1_out_data,
    input  arr_rstn, arr_en_in_data, arr_in_mat, arr_in_new_row, arr_in_mat_done, arr_in_data,
    input  arr_rdy_out_data,
    output arr_rdy_in_data, arr_en_out_data, arr_out_data
  );

endinterface
`default_nettype wire

// File: rtl/fxp8s_rr_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fxp8s_rr_sel: 2-way round-robin selector, pointer rr wins a tie.          |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module fxp8s_rr_sel (
  input  logic [1:0] req,
  input  logic       rr,
  output logic       grant_valid,
  output logic       grant_idx
);

  assign grant_valid = |req;
  assign grant_idx   = req[rr] ? rr : ~rr;

endmodule
`default_nettype wire

// File: rtl/fxp8s_array_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fxp8s_array_arbiter: shares one PE array between two requesters, one job  |
// | at a time. Optional watchdog abort: FXP8S_ARB_WATCHDOG_EN.                |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module fxp8s_array_arbiter
  import fxp8s_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fxp8s_array_arbiter_if.slave bus,
  output logic                 busy,
  output logic                 owner
`ifdef FXP8S_ARB_WATCHDOG_EN
  ,
  output logic                 abort
`endif
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] BEAT_LAST  = 4'(BEATS_PER_JOB - 1);

  state_t     state, state_nxt;
  logic       rr, grant_valid, grant_idx, out_hs;
  logic [3:0] beat_cnt, flush_cnt;
`ifdef FXP8S_ARB_WATCHDOG_EN
  logic [9:0] wd_cnt;
  logic       in_hs, wd_fire;
`endif

  fxp8s_rr_sel u_rr_sel (
    .req         ({bus.req1_en_in_data, bus.req0_en_in_data}),
    .rr          (rr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_nxt            = state;
    out_hs               = 1'b0;
    bus.arr_rstn         = ~rst & (state != ST_FLUSH);
    bus.arr_en_in_data   = 1'b0;
    bus.arr_in_mat       = 1'b0;
    bus.arr_in_new_row   = 1'b0;
    bus.arr_in_mat_done  = 1'b0;
    bus.arr_in_data      = '0;
    bus.arr_rdy_out_data = 1'b0;
    bus.req0_rdy_in_data = 1'b0;
    bus.req1_rdy_in_data = 1'b0;
    bus.req0_en_out_data = 1'b0;
    bus.req1_en_out_data = 1'b0;
    bus.req0_out_data    = '0;
    bus.req1_out_data    = '0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (owner) begin
          bus.arr_en_in_data   = bus.req1_en_in_data;
          bus.arr_in_mat       = bus.req1_in_mat;
          bus.arr_in_new_row   = bus.req1_in_new_row;
          bus.arr_in_mat_done  = bus.req1_in_mat_done;
          bus.arr_in_data      = bus.req1_in_data;
          bus.req1_rdy_in_data = bus.arr_rdy_in_data;
        end else begin
          bus.arr_en_in_data   = bus.req0_en_in_data;
          bus.arr_in_mat       = bus.req0_in_mat;
          bus.arr_in_new_row   = bus.req0_in_new_row;
          bus.arr_in_mat_done  = bus.req0_in_mat_done;
          bus.arr_in_data      = bus.req0_in_data;
          bus.req0_rdy_in_data = bus.arr_rdy_in_data;
        end
        if (bus.arr_en_out_data) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (owner) begin
          bus.req1_en_out_data = bus.arr_en_out_data;
          bus.req1_out_data    = bus.arr_out_data;
          bus.arr_rdy_out_data = bus.req1_rdy_out_data;
        end else begin
          bus.req0_en_out_data = bus.arr_en_out_data;
          bus.req0_out_data    = bus.arr_out_data;
          bus.arr_rdy_out_data = bus.req0_rdy_out_data;
        end
        out_hs = bus.arr_en_out_data & bus.arr_rdy_out_data;
        if (out_hs && beat_cnt == BEAT_LAST) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_cnt == FLUSH_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
`ifdef FXP8S_ARB_WATCHDOG_EN
    // A stalled job is torn down through the normal flush path
    in_hs   = bus.arr_en_in_data & bus.arr_rdy_in_data;
    wd_fire = ((state == ST_BUSY) || (state == ST_DRAIN)) && (wd_cnt == 10'd1023);
    abort   = wd_fire;
    if (wd_fire) state_nxt = ST_FLUSH;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr        <= 1'b0;
      owner     <= 1'b0;
      beat_cnt  <= 4'd0;
      flush_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && grant_valid) owner <= grant_idx;
      if (out_hs) beat_cnt <= beat_cnt + 4'd1;
      if (state == ST_FLUSH) begin
        if (flush_cnt == FLUSH_LAST) begin
          flush_cnt <= 4'd0;
          beat_cnt  <= 4'd0;
          rr        <= ~owner;
        end else begin
          flush_cnt <= flush_cnt + 4'd1;
        end
      end
    end
  end

`ifdef FXP8S_ARB_WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= 10'd0;
    end else if (((state == ST_BUSY) || (state == ST_DRAIN)) && !wd_fire && !(in_hs || out_hs)) begin
      wd_cnt <= wd_cnt + 10'd1;
    end else begin
      wd_cnt <= 10'd0;
    end
  end
`endif

endmodule
`default_nettype wire
